axi3_sram_slave: RTL and testbench
==================================

// Module: axi3_sram_slave
// PURPOSE
// - AXI3 slave responder backed by an on-chip word RAM; the memory-side counterpart of the CPU/cache AXI master.
// - Serves as boot RAM in the SoC and as the memory model in core-level simulation.
// - Read and write channels run independently; each accepts one burst at a time.
// PARAMETERS
// - ADDR_W      default 16  byte-address bits decoded; higher bits ignored, so accesses alias modulo 2**ADDR_W bytes
// - ID_W        default 4   AXI ID width
// - INIT_FILE   default ""  $readmemh image; empty means no initialisation
// PORTS
// - aclk                      in   1     clock
// - aresetn                   in   1     synchronous, active-low reset
// - arid/araddr/arlen         in   ID_W/32/4   read address channel
// - arsize/arburst            in   3/2   read address channel
// - arvalid                   in   1     read address valid
// - arready                   out  1     read address ready
// - rid/rdata/rresp/rlast     out  ID_W/32/2/1   read data channel
// - rvalid                    out  1     read data valid
// - rready                    in   1     read data ready
// - awid/awaddr/awlen         in   ID_W/32/4   write address channel
// - awsize/awburst            in   3/2   write address channel
// - awvalid                   in   1     write address valid
// - awready                   out  1     write address ready
// - wid/wdata/wstrb/wlast     in   ID_W/32/4/1   write data channel (wid ignored)
// - wvalid                    in   1     write data valid
// - wready                    out  1     write data ready
// - bid/bresp                 out  ID_W/2   write response channel
// - bvalid                    out  1     write response valid
// - bready                    in   1     write response ready
// - arlock/arcache/arprot, awlock/awcache/awprot: accepted and ignored.
// BEHAVIOUR
// - Reset: all FSMs go to IDLE; arready=awready=1; rvalid=wready=bvalid=0; rlast=0; rresp=bresp=0.
//   RAM contents are not cleared. Reset asserted mid-burst abandons that burst immediately.
// - Read FSM, R_IDLE -> R_DATA:
//   - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/size/burst, issue a RAM read of word addr, go to R_DATA.
//   - R_DATA: rvalid=1. rdata is the RAM output register, so the first beat appears the cycle after the AR handshake.
//   - On rvalid&rready&!rlast: advance address and issue the next RAM read. Full throughput, one beat per cycle.
//   - rdata and rlast hold while rready=0.
//   - rlast=1 on beat index == len. Handshake of that beat returns to R_IDLE; arready reasserts on the following cycle.
// - Write FSM, W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: awready=1. On handshake, latch burst fields, go to W_DATA.
//   - W_DATA: wready=1. Each beat writes bytes selected by wstrb at the current word, then the address advances.
//   - The beat carrying wlast moves to W_RESP.
//   - W_RESP: bvalid=1, bid=latched awid; return to W_IDLE on bready.
// - Address generation:
//   - FIXED: address held.
//   - INCR: +4 per beat.
//   - WRAP: wrap at a (len+1)*4-byte boundary; len must be 1, 3, 7 or 15.
//   - Any other WRAP len, or burst=2'b11, gives SLVERR.
// - Error responses (SLVERR=2'b10):
//   - arsize or awsize != 3'b010.
//   - Illegal burst.
//   - wlast arriving at a beat index != awlen, or beat index awlen reached without wlast.
//   - Errored read bursts still return len+1 beats with rdata=0 and rresp=SLVERR on every beat.
//   - Errored write beats do not modify the RAM.
//   - A wlast/len mismatch does not roll back beats already written. The burst always terminates on wlast.
// - Same-word read/write in one cycle: read-first. The read returns old data; the write lands.
// - Address bits [1:0] are ignored. Unaligned addresses are treated as aligned.
// CONFIGURATION
// - AXI_SRAM_STALL_EN defined:
//   - A 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) steps every cycle.
//   - LFSR bit0=0 forces arready, awready and wready to 0 that cycle.
//   - LFSR bit1=0 delays the entry into R_DATA/W_RESP by one cycle.
//   - Once rvalid or bvalid is asserted it is never dropped before its handshake.
// - AXI_SRAM_STALL_EN undefined: no LFSR; timing exactly as in BEHAVIOUR.
// STRUCTURE
// - Shared package axi_pkg:
//   - burst_t enum: FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
//   - resp constants: OKAY=2'b00, SLVERR=2'b10.
//   - Read FSM enum {R_IDLE, R_DATA} and write FSM enum {W_IDLE, W_DATA, W_RESP}.
// - One sub-module, axi_burst_addr_gen:
//   - Combinational next-address for FIXED/INCR/WRAP plus legality flag.
//   - Instantiated twice, once for reads and once for writes.
// - RAM: single array with one read and one byte-enabled write port, inferred as BRAM.
// TESTING
// - INCR read, araddr=0x100, arlen=3, rready=1:
//   - rvalid on cycle+1.
//   - Four consecutive beats from words 0x100..0x10C.
//   - rlast only on beat 3; rresp=OKAY; rid=arid.
// - WRAP write, awaddr=0x218, awlen=3, wstrb=4'hF:
//   - Writes hit 0x218, 0x21C, 0x210, 0x214.
//   - Readback matches.
//   - bresp=OKAY, bid=awid.
// - Byte strobes: pre-fill 0x40 with 32'hFFFFFFFF, single-beat write wdata=32'h12345678 wstrb=4'b0101 -> readback 32'hFF34FF78.
// - Backpressure: INCR read arlen=7 with rready toggling 1,0,0,1 -> rdata/rlast stable while stalled; exactly 8 beats delivered.
// - Error cases:
//   - arsize=3'b001, arlen=1 -> 2 beats with rresp=SLVERR.
//   - awlen=3 with wlast on beat 1 -> burst ends after beat 1, bresp=SLVERR.
// - Reset: assert aresetn=0 during beat 2 of an arlen=7 read -> next cycle rvalid=0, arready=1; a new read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : axi_pkg
// Description : AXI3 burst encodings, response codes and slave FSM states.
// Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY      = 2'b00;
  localparam logic [1:0] SLVERR    = 2'b10;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // A wrapping burst must span a power-of-two number of beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Next-beat byte address for FIXED/INCR/WRAP word bursts and
//               a legality flag covering size and burst/len combinations.
// Revision    : 1.0  initial release
// ============================================================================
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              legal
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  // Address step per burst type; the wrap window is (len+1) words wide.
  always_comb begin
    incr_addr = addr + ADDR_W'(4);
    wrap_mask = ADDR_W'({len, 2'b11});
    next_addr = addr;
    legal     = (size == SIZE_WORD);
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_addr;
      WRAP: begin
        next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        legal     = legal && wrap_len_ok(len);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi3_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi3_sram_slave
// Description : AXI3 slave backed by a byte-writable word RAM. Independent
//               read and write channels, one burst in flight on each.
//               Optional macro AXI_SRAM_STALL_EN adds LFSR-driven stalls.
// Revision    : 1.0  initial release
// ============================================================================
module axi3_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ID_W      = 4,
  parameter     INIT_FILE = ""
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  logic [31:0] mem [WORDS];
  logic [31:0] ram_rdata_q;
  logic        ram_ren;
  logic [ADDR_W-3:0] ram_raddr;
  logic        ram_wen;

  logic stall_ok;
  logic stall_delay;

`ifdef AXI_SRAM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, advancing every cycle.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // LFSR state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign stall_ok    = lfsr_q[0];
  assign stall_delay = ~lfsr_q[1];
`else
  assign stall_ok    = 1'b1;
  assign stall_delay = 1'b0;
`endif

  // ---------------------------------------------------------------- read side
  rd_state_t         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [3:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic              rhold_q, rhold_d;
  logic [ADDR_W-1:0] rd_next;
  logic              rd_legal;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr (
    .addr(raddr_q), .len(rlen_q), .size(rsize_q), .burst(rburst_q),
    .next_addr(rd_next), .legal(rd_legal)
  );

  // Read FSM: capture AR, then stream beats straight from the RAM output register.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rhold_d    = 1'b0;
    ram_ren    = 1'b0;
    ram_raddr  = raddr_q[ADDR_W-1:2];
    arready    = 1'b0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    rresp      = OKAY;
    rdata      = '0;
    rid        = rid_q;
    case (rd_state_q)
      R_IDLE: begin
        arready = stall_ok;
        if (arvalid && stall_ok) begin
          rid_d      = arid;
          raddr_d    = {araddr[ADDR_W-1:2], 2'b00};
          rlen_d     = arlen;
          rsize_d    = arsize;
          rburst_d   = arburst;
          rbeat_d    = 4'd0;
          ram_ren    = 1'b1;
          ram_raddr  = araddr[ADDR_W-1:2];
          rhold_d    = stall_delay;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = !rhold_q;
        rlast  = (rbeat_q == rlen_q);
        rresp  = rd_legal ? OKAY : SLVERR;
        rdata  = rd_legal ? ram_rdata_q : '0;
        if (rvalid && rready) begin
          if (rlast) begin
            rd_state_d = R_IDLE;
          end else begin
            rbeat_d   = rbeat_q + 4'd1;
            raddr_d   = rd_next;
            ram_ren   = 1'b1;
            ram_raddr = rd_next[ADDR_W-1:2];
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rhold_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rbeat_q    <= rbeat_d;
      rhold_q    <= rhold_d;
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [3:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;
  logic              bhold_q, bhold_d;
  logic              wbeat_bad;
  logic [ADDR_W-1:0] wr_next;
  logic              wr_legal;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr (
    .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q),
    .next_addr(wr_next), .legal(wr_legal)
  );

  // Write FSM: a beat is bad when wlast disagrees with awlen; once bad, the rest are too.
  always_comb begin
    wr_state_d = wr_state_q;
    bid_d      = bid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    werr_d     = werr_q;
    bhold_d    = 1'b0;
    wbeat_bad  = (wlast != (wbeat_q == wlen_q)) || werr_q;
    ram_wen    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    bresp      = OKAY;
    bid        = bid_q;
    case (wr_state_q)
      W_IDLE: begin
        awready = stall_ok;
        if (awvalid && stall_ok) begin
          bid_d      = awid;
          waddr_d    = {awaddr[ADDR_W-1:2], 2'b00};
          wlen_d     = awlen;
          wsize_d    = awsize;
          wburst_d   = awburst;
          wbeat_d    = 4'd0;
          werr_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = stall_ok;
        if (wvalid && stall_ok) begin
          ram_wen = wr_legal && !wbeat_bad;
          waddr_d = wr_next;
          wbeat_d = wbeat_q + 4'd1;
          werr_d  = wbeat_bad;
          if (wlast) begin
            bhold_d    = stall_delay;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid = !bhold_q;
        bresp  = (wr_legal && !werr_q) ? OKAY : SLVERR;
        if (bvalid && bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      bid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      werr_q     <= 1'b0;
      bhold_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      bid_q      <= bid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      werr_q     <= werr_d;
      bhold_q    <= bhold_d;
    end
  end

  // --------------------------------------------------------------------- RAM
  // Read-first RAM: a same-cycle read of the written word returns the old value.
  always_ff @(posedge aclk) begin
    if (ram_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr_q[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ram_ren) ram_rdata_q <= mem[ram_raddr];
  end

  // Sideband fields and address bits outside the decoded window carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{araddr[31:ADDR_W], araddr[1:0], awaddr[31:ADDR_W], awaddr[1:0],
                       wid, arlock, arcache, arprot, awlock, awcache, awprot};

endmodule
`default_nettype wire

// File: tb/tb_axi3_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi3_sram_slave
// Description : Directed and randomized bench for axi3_sram_slave with a
//               word-array reference model of the RAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi3_sram_slave;

  localparam int ID_W = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [ID_W-1:0] arid, awid, wid;
  logic [31:0]     araddr, awaddr, wdata;
  logic [3:0]      arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock;
  logic            arvalid, rready, awvalid, wlast, wvalid, bready;
  logic            arready, rlast, rvalid, awready, wready, bvalid;
  logic [ID_W-1:0] rid, bid;
  logic [31:0]     rdata;
  logic [1:0]      rresp, bresp;

  axi3_sram_slave #(.ADDR_W(16), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] model [0:16383];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Byte address of beat i, from the AXI burst rules, modulo 64 KiB.
  function automatic logic [15:0] beat_addr(input logic [31:0] addr, input int len,
                                            input logic [1:0] burst, input int i);
    int a, sz, base;
    a = int'(addr & 32'h0000_FFFC);
    case (burst)
      2'b00: return 16'(a);
      2'b10: begin
        sz   = (len + 1) * 4;
        base = (a / sz) * sz;
        return 16'(base + ((a - base + 4 * i) % sz));
      end
      default: return 16'(a + 4 * i);
    endcase
  endfunction

  function automatic bit burst_ok(input logic [2:0] size, input int len, input logic [1:0] burst);
    if (size != 3'd2) return 1'b0;
    if (burst == 2'b00 || burst == 2'b01) return 1'b1;
    if (burst == 2'b10) return (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  // Beat i carries data0+i; the burst ends with wlast on beat last_at.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb_in,
                          input bit rand_strb, input int last_at, input logic [31:0] data0);
    bit legal, err, bad;
    int n;
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] ba;
    legal = burst_ok(size, len, burst);
    err   = !legal;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    chk("awready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      d = data0 + 32'(i);
      s = rand_strb ? 4'($urandom) : strb_in;
      wid = id; wdata = d; wstrb = s; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      chk("wready", wready, 1);
      bad = ((i == last_at) != (i == len)) || (i > len);
      if (bad) err = 1'b1;
      if (legal && !bad) begin
        ba = beat_addr(addr, len, burst, i);
        for (int b = 0; b < 4; b++)
          if (s[b]) model[ba[15:2]][8*b +: 8] = d[8*b +: 8];
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    n = $urandom_range(0, 2);
    repeat (n) tick();
    chk("bvalid_hold", bvalid, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_done", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  // mode 0: rready=1; mode 1: rready 1,0,0,1 repeating; mode 2: random.
  // abort_at >= 0 pulls aresetn low while that beat is on the bus.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input int mode,
                         input int abort_at, output logic [31:0] last_data);
    bit legal;
    int beat, cyc;
    logic [31:0] exp_d;
    logic [15:0] ba;
    legal = burst_ok(size, len, burst);
    beat = 0; cyc = 0; last_data = '0;
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    chk("arready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_first", rvalid, 1);
    while (beat <= len && cyc < 300) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rready = 1'($urandom);
      endcase
      ba    = beat_addr(addr, len, burst, beat);
      exp_d = legal ? model[ba[15:2]] : 32'h0;
      last_data = exp_d;
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, legal ? 2'b00 : 2'b10);
      chk("rlast", rlast, beat == len);
      chk("rid", rid, id);
      if (beat == abort_at) begin
        aresetn = 1'b0;
        tick();
        chk("rst_rvalid", rvalid, 0);
        chk("rst_arready", arready, 1);
        chk("rst_rlast", rlast, 0);
        aresetn = 1'b1;
        rready  = 1'b0;
        tick();
        return;
      end
      if (rready) beat++;
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("read_beats", beat, len + 1);
    chk("rvalid_end", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] ld;
    logic [31:0] ra;
    int          rl;
    logic [1:0]  rb;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    aresetn = 1'b1;
    tick();

    // INCR read of four words at 0x100
    do_write(4'h1, 32'h100, 3, 2'b01, 3'd2, 4'hF, 1'b0, 3, $urandom);
    do_read(4'h5, 32'h100, 3, 2'b01, 3'd2, 0, -1, ld);

    // WRAP write at 0x218 lands at 218,21C,210,214
    do_write(4'h6, 32'h218, 3, 2'b10, 3'd2, 4'hF, 1'b0, 3, 32'hA0B0_C000);
    do_read(4'h2, 32'h210, 3, 2'b01, 3'd2, 0, -1, ld);
    do_read(4'h2, 32'h210, 0, 2'b01, 3'd2, 0, -1, ld);
    chk("wrap_word_210", ld, 32'hA0B0_C002);
    do_read(4'h2, 32'h218, 0, 2'b01, 3'd2, 0, -1, ld);
    chk("wrap_word_218", ld, 32'hA0B0_C000);

    // Byte strobes
    do_write(4'h3, 32'h40, 0, 2'b01, 3'd2, 4'hF, 1'b0, 0, 32'hFFFF_FFFF);
    do_write(4'h3, 32'h40, 0, 2'b01, 3'd2, 4'b0101, 1'b0, 0, 32'h1234_5678);
    do_read(4'h3, 32'h40, 0, 2'b01, 3'd2, 0, -1, ld);
    chk("strobe_merge", ld, 32'hFF34_FF78);

    // Backpressure on an 8-beat read
    do_write(4'h4, 32'h300, 7, 2'b01, 3'd2, 4'hF, 1'b0, 7, $urandom);
    do_read(4'h9, 32'h300, 7, 2'b01, 3'd2, 1, -1, ld);

    // Error responses
    do_read(4'hA, 32'h100, 1, 2'b01, 3'd1, 0, -1, ld);
    do_read(4'hB, 32'h100, 2, 2'b11, 3'd2, 0, -1, ld);
    do_read(4'hC, 32'h210, 2, 2'b10, 3'd2, 0, -1, ld);
    do_write(4'h7, 32'h500, 0, 2'b01, 3'd2, 4'hF, 1'b0, 0, 32'h0BAD_0000);
    do_write(4'h7, 32'h500, 3, 2'b01, 3'd2, 4'hF, 1'b0, 1, 32'h5555_0000);
    do_read(4'h7, 32'h500, 0, 2'b01, 3'd2, 0, -1, ld);
    do_write(4'h8, 32'h100, 1, 2'b01, 3'd0, 4'hF, 1'b0, 1, 32'hDEAD_0000);
    do_read(4'h8, 32'h100, 3, 2'b01, 3'd2, 0, -1, ld);

    // Aliasing above the decoded window and unaligned addresses
    do_read(4'hD, 32'h0001_0100, 3, 2'b01, 3'd2, 0, -1, ld);
    do_read(4'hD, 32'h0000_0106, 1, 2'b01, 3'd2, 0, -1, ld);

    // Reset in the middle of a burst, then a clean read
    do_read(4'hE, 32'h300, 7, 2'b01, 3'd2, 0, 2, ld);
    do_read(4'hF, 32'h300, 7, 2'b01, 3'd2, 0, -1, ld);

    // Randomized bursts
    for (int k = 0; k < 20; k++) begin
      rb = 2'($urandom_range(0, 2));
      if (rb == 2'b10) rl = (1 << $urandom_range(1, 4)) - 1;
      else             rl = $urandom_range(0, 15);
      ra = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      do_write(4'($urandom), ra, rl, rb, 3'd2, 4'hF, 1'b0, rl, $urandom);
      do_write(4'($urandom), ra, rl, rb, 3'd2, 4'h0, 1'b1, rl, $urandom);
      do_read(4'($urandom), ra, rl, rb, 3'd2, 2, -1, ld);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
